// File: rtl/pad_pkg.sv
// Shared types and constants for the two-pad serial poll controller.
package pad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SAMPLE = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } poll_state_t;

  localparam int unsigned PAD_COUNT = 2;

  // Button bit positions in a published byte
  localparam int unsigned BTN_A     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_SEL   = 2;
  localparam int unsigned BTN_START = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;

endpackage

// File: rtl/pad_edge_reg.sv
// Per-pad button register with press/release edge masks.
// PAD_DEBOUNCE_EN: accept a new byte only when two consecutive polls agree.
module pad_edge_reg #(
  parameter int unsigned NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                update,
  input  logic [NUM_BITS-1:0] din,
  output logic [NUM_BITS-1:0] btn,
  output logic [NUM_BITS-1:0] press,
  output logic [NUM_BITS-1:0] rel
);

  logic [NUM_BITS-1:0] btn_next;

`ifdef PAD_DEBOUNCE_EN
  logic [NUM_BITS-1:0] raw;

  always_comb begin
    btn_next = btn;
    if (din == raw) btn_next = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      raw <= '0;
    else if (update) raw <= din;
  end
`else
  always_comb begin
    btn_next = din;
  end
`endif

  // Edge masks fall to zero on their own when btn holds its value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn   <= '0;
      press <= '0;
      rel   <= '0;
    end else if (update) begin
      btn   <= btn_next;
      press <= btn_next & ~btn;
      rel   <= ~btn_next & btn;
    end
  end

endmodule

// File: rtl/pad_poll_ctrl.sv
// Latch/clock/sample sequencer for two serial pads on shared latch and clock.
// Optional PAD_DEBOUNCE_EN is handled inside pad_edge_reg.
module pad_poll_ctrl
  import pad_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 20,
  parameter int unsigned POLL_INTERVAL = 100000,
  parameter int unsigned NUM_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAD_COUNT-1:0] pad_data,
  output logic                 pad_latch,
  output logic                 pad_clock,
  input  logic                 poll_req,
  output logic                 poll_ack,
  output logic                 poll_valid,
  output logic                 busy,
  output logic [NUM_BITS-1:0]  btn0,
  output logic [NUM_BITS-1:0]  btn1,
  output logic [NUM_BITS-1:0]  press0,
  output logic [NUM_BITS-1:0]  press1,
  output logic [NUM_BITS-1:0]  rel0,
  output logic [NUM_BITS-1:0]  rel1
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned INT_W = $clog2(POLL_INTERVAL + 1);
  localparam int unsigned BIT_W = $clog2(NUM_BITS);

  poll_state_t         state;
  logic [DIV_W-1:0]    div_cnt;
  logic [INT_W-1:0]    int_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [NUM_BITS-1:0] sh0;
  logic [NUM_BITS-1:0] sh1;
  logic                auto_pend;
  logic                req_pend;
  logic                served;
  logic                tick;
  logic                upd;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign upd  = (state == DONE);
  assign busy = (state != IDLE);

  // Free-running phase divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Idle-time interval counter; saturates with auto_pend raised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt   <= '0;
      auto_pend <= 1'b0;
    end else if (state == DONE) begin
      int_cnt   <= '0;
      auto_pend <= 1'b0;
    end else if (state == IDLE && !auto_pend) begin
      if (int_cnt == INT_W'(POLL_INTERVAL - 1)) auto_pend <= 1'b1;
      else                                      int_cnt   <= int_cnt + INT_W'(1);
    end
  end

  // A request captured after a poll started stays pending for the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    req_pend <= 1'b0;
    else if (state == DONE && served)              req_pend <= 1'b0;
    else if (poll_req && !req_pend && !poll_ack)   req_pend <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pad_latch  <= 1'b0;
      pad_clock  <= 1'b0;
      bit_cnt    <= '0;
      sh0        <= '0;
      sh1        <= '0;
      served     <= 1'b0;
      poll_valid <= 1'b0;
      poll_ack   <= 1'b0;
    end else begin
      poll_valid <= 1'b0;
      poll_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && (auto_pend || req_pend)) begin
            pad_latch <= 1'b1;
            bit_cnt   <= '0;
            served    <= req_pend;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (tick) begin
            pad_latch <= 1'b0;
            state     <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (tick) begin
            sh0 <= {~pad_data[0], sh0[NUM_BITS-1:1]};
            sh1 <= {~pad_data[1], sh1[NUM_BITS-1:1]};
            if (bit_cnt == BIT_W'(NUM_BITS - 1)) begin
              state <= DONE;
            end else begin
              pad_clock <= 1'b1;
              state     <= CLK_HI;
            end
          end
        end
        CLK_HI: begin
          if (tick) begin
            pad_clock <= 1'b0;
            bit_cnt   <= bit_cnt + BIT_W'(1);
            state     <= SAMPLE;
          end
        end
        DONE: begin
          poll_valid <= 1'b1;
          poll_ack   <= served;
          served     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pad_edge_reg #(.NUM_BITS(NUM_BITS)) u_pad0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .update (upd),
    .din    (sh0),
    .btn    (btn0),
    .press  (press0),
    .rel    (rel0)
  );

  pad_edge_reg #(.NUM_BITS(NUM_BITS)) u_pad1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .update (upd),
    .din    (sh1),
    .btn    (btn1),
    .press  (press1),
    .rel    (rel1)
  );

endmodule

// File: tb/tb_pad_poll_ctrl.sv
// Self-checking bench for pad_poll_ctrl with two behavioural shift-register pads.
module tb_pad_poll_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned PI = 200;
  localparam int unsigned NB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       poll_req = 1'b0;
  logic [1:0] pad_data;
  logic       pad_latch, pad_clock, poll_ack, poll_valid, busy;
  logic [7:0] btn0, btn1, press0, press1, rel0, rel1;

  pad_poll_ctrl #(.TICK_DIV(TD), .POLL_INTERVAL(PI), .NUM_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clock(pad_clock),
    .poll_req(poll_req), .poll_ack(poll_ack), .poll_valid(poll_valid), .busy(busy),
    .btn0(btn0), .btn1(btn1), .press0(press0), .press1(press1), .rel0(rel0), .rel1(rel1)
  );

  always #5 clk = ~clk;

  // Pads: pressed masks, active-low serial output, bit0 first after latch
  logic [7:0] m0 = 8'h00, m1 = 8'h00;
  logic [2:0] idx = 3'd0;
  always @(posedge pad_latch or posedge pad_clock) begin
    if (pad_latch) idx <= 3'd0;
    else           idx <= idx + 3'd1;
  end
  assign pad_data = {~m1[idx], ~m0[idx]};

  typedef struct packed {
    logic [7:0] b0, b1, p0, p1, r0, r1;
    logic       ack;
  } exp_t;

  exp_t obs;
  assign obs = {btn0, btn1, press0, press1, rel0, rel1, poll_ack};

  exp_t sb[$];
  logic [7:0] mb0 = 8'h00, mb1 = 8'h00;
`ifdef PAD_DEBOUNCE_EN
  logic [7:0] mr0 = 8'h00, mr1 = 8'h00;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model of one poll's published result, queued in poll order
  task automatic sb_push(input logic [7:0] n0, input logic [7:0] n1, input logic ack);
    exp_t e;
    logic [7:0] v0, v1;
    v0 = n0;
    v1 = n1;
`ifdef PAD_DEBOUNCE_EN
    if (n0 != mr0) v0 = mb0;
    if (n1 != mr1) v1 = mb1;
    mr0 = n0;
    mr1 = n1;
`endif
    e.b0 = v0;  e.b1 = v1;
    e.p0 = v0 & ~mb0;  e.p1 = v1 & ~mb1;
    e.r0 = ~v0 & mb0;  e.r1 = ~v1 & mb1;
    e.ack = ack;
    mb0 = v0;
    mb1 = v1;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int budget, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step();
      n++;
      got = poll_valid;
    end
  endtask

  task automatic wait_latch(input int budget, output bit got, output int n);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step();
      n++;
      got = pad_latch;
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({pad_latch, pad_clock} !== 2'b00) begin
      n_bad++; $display("FAIL reset_pins: got %b, expected 00", {pad_latch, pad_clock});
    end
    n_cmp++;
    if ({poll_valid, poll_ack, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes: got %b, expected 000", {poll_valid, poll_ack, busy});
    end
    n_cmp++;
    if ({btn0, btn1} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_btn: got %h, expected 0000", {btn0, btn1});
    end
    n_cmp++;
    if ({press0, press1, rel0, rel1} !== 32'h0) begin
      n_bad++; $display("FAIL reset_edges: got %h, expected 0", {press0, press1, rel0, rel1});
    end
  endtask

  // First auto poll after reset: sequence timing and A-pressed result
  task automatic test_auto_timing();
    int rise = -1, vcyc = -1, lhi = 0, npul = 0, bad_w = 0, w = 0;
    logic pc_d = 1'b0;
    exp_t e;
    m0 = 8'h01;
    m1 = 8'h00;
    sb_push(m0, m1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (vcyc < 0 && cyc < 400) begin
      step();
      if (pad_latch) begin
        lhi++;
        if (rise < 0) rise = cyc;
      end
      if (pad_clock) w++;
      else if (pc_d) begin
        npul++;
        if (w != TD) bad_w++;
        w = 0;
      end
      pc_d = pad_clock;
      if (poll_valid) vcyc = cyc;
    end
    // auto_pend rises at clock PI; latch follows on the next multiple of TD
    n_cmp++;
    if (rise != int'((PI / TD + 1) * TD)) begin
      n_bad++; $display("FAIL auto_latch_rise: got %0d, expected %0d", rise, (PI / TD + 1) * TD);
    end
    n_cmp++;
    if (lhi != int'(TD)) begin
      n_bad++; $display("FAIL latch_width: got %0d, expected %0d", lhi, TD);
    end
    n_cmp++;
    if (npul != int'(NB - 1) || bad_w != 0) begin
      n_bad++; $display("FAIL clock_pulses: got %0d pulses %0d bad widths, expected %0d and 0", npul, bad_w, NB - 1);
    end
    // 2*NB ticks then the DONE clock
    n_cmp++;
    if (vcyc < 0 || (vcyc - rise) != int'(2 * NB * TD + 1)) begin
      n_bad++; $display("FAIL valid_latency: got %0d, expected %0d", vcyc - rise, 2 * NB * TD + 1);
    end
    n_cmp++;
    if (vcyc >= 0) begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_bad++; $display("FAIL auto_result: got %h, expected %h", obs, e);
      end
    end else begin
      n_bad++; $display("FAIL auto_result: got no poll_valid, expected one");
    end
  endtask

  // Host request from IDLE; no follow-on poll before the interval
  task automatic test_req();
    bit got;
    int n, lat = 0;
    exp_t e;
    repeat (20) step();
    m1 = 8'h80;
    sb_push(m0, m1, 1'b1);
    poll_req = 1'b1;
    wait_latch(20, got, n);
    n_cmp++;
    if (!got || n < 2 || n > int'(TD + 1)) begin
      n_bad++; $display("FAIL req_start: got %0d clocks, expected 2..%0d", n, TD + 1);
    end
    wait_valid(200, got, n);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL req_result: got no poll_valid, expected one");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_bad++; $display("FAIL req_result: got %h, expected %h", obs, e);
      end
    end
    poll_req = 1'b0;
    repeat (150) begin
      step();
      if (pad_latch || busy) lat++;
    end
    n_cmp++;
    if (lat != 0) begin
      n_bad++; $display("FAIL req_no_repeat: got %0d busy clocks, expected 0", lat);
    end
  endtask

  // Request during an auto poll is served by the following poll
  task automatic test_mid_req();
    bit got;
    int n, rises = 0;
    logic pc_d = 1'b0;
    exp_t e;
    m0 = 8'h00;
    sb_push(m0, m1, 1'b0);
    wait_latch(300, got, n);
    while (rises < 3 && n < 600) begin
      step();
      n++;
      if (pad_clock && !pc_d) rises++;
      pc_d = pad_clock;
    end
    poll_req = 1'b1;
    sb_push(8'h01, m1, 1'b1);
    wait_valid(200, got, n);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL mid_first: got no poll_valid, expected one");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_bad++; $display("FAIL mid_first: got %h, expected %h", obs, e);
      end
    end
    m0 = 8'h01;
    wait_latch(20, got, n);
    // DONE was one clock after a tick, so the next tick is TD-1 clocks away
    n_cmp++;
    if (!got || n != int'(TD - 1)) begin
      n_bad++; $display("FAIL mid_second_start: got %0d clocks, expected %0d", n, TD - 1);
    end
    wait_valid(200, got, n);
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL mid_second: got no poll_valid, expected one");
    end else begin
      e = sb.pop_front();
      if (obs !== e) begin
        n_bad++; $display("FAIL mid_second: got %h, expected %h", obs, e);
      end
    end
    poll_req = 1'b0;
  endtask

  // Asynchronous reset during CLK_HI clears pins and results at once
  task automatic test_reset_mid();
    bit got = 1'b0;
    int n = 0, v = 0;
    step();
    poll_req = 1'b1;
    while (!got && n < 100) begin
      step();
      n++;
      got = pad_clock;
    end
    rst_n = 1'b0;
    poll_req = 1'b0;
    #1;
    n_cmp++;
    if (!got || {pad_latch, pad_clock} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_pins: got %b (clk seen %0d), expected 00", {pad_latch, pad_clock}, got);
    end
    n_cmp++;
    if ({btn0, btn1, busy} !== 17'h0) begin
      n_bad++; $display("FAIL reset_mid_state: got %h, expected 0", {btn0, btn1, busy});
    end
    mb0 = 8'h00;
    mb1 = 8'h00;
`ifdef PAD_DEBOUNCE_EN
    mr0 = 8'h00;
    mr1 = 8'h00;
`endif
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      step();
      if (poll_valid) v++;
    end
    n_cmp++;
    if (v != 0) begin
      n_bad++; $display("FAIL reset_mid_no_publish: got %0d valid pulses, expected 0", v);
    end
  endtask

`ifdef PAD_DEBOUNCE_EN
  // Alternating raw bytes never agree, so btn0 must stay clear
  task automatic test_debounce();
    bit got;
    int n;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      m0 = (i % 2 == 0) ? 8'h01 : 8'h00;
      sb_push(m0, m1, 1'b1);
      poll_req = 1'b1;
      wait_valid(200, got, n);
      poll_req = 1'b0;
      n_cmp++;
      if (!got) begin
        n_bad++; $display("FAIL debounce_poll: got no poll_valid, expected one");
      end else begin
        e = sb.pop_front();
        if (obs !== e || btn0 !== 8'h00) begin
          n_bad++; $display("FAIL debounce_poll: got %h, expected %h", obs, e);
        end
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_auto_timing();
    test_req();
    test_mid_req();
    test_reset_mid();
`ifdef PAD_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
